// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the run/pause/clear controller.
// The state enum and decode helper are common to the FSM and any bound checker.
package count_ctrl_pkg;

  localparam int DEF_PRESCALE  = 1000;
  localparam int DEF_DB_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  // Observation bundle for checkers bound onto count_ctrl.
  typedef struct packed {
    state_e state;
    logic   run_level;
    logic   clear_level;
  } ctrl_dbg_t;

  // The unused encoding 2'd3 is treated as IDLE so a corrupted state self-recovers.
  function automatic state_e decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    return ST_RUNNING;
      2'd2:    return ST_PAUSED;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/count_ctrl_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button.
// press is combinational: high on the edge where the debounced level rises.
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Sample count reached: accept the new level; only a rising level is an event.
      db_d  = sync2_q;
      cnt_d = '0;
      press = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = db_q;

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear controller feeding a decade counter: debounced buttons drive a
// three-state FSM and a prescaler that emits one-cycle enable ticks and clear pulses.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_clear,
  output logic enable,
  output logic clear,
  output logic running
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  logic run_level, run_press;
  logic clear_level, clear_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_run),
    .level   (run_level),
    .press   (run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clear),
    .level   (clear_level),
    .press   (clear_press)
  );

  state_e        state_q, state_d;
  state_e        state_cur;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          enable_q, enable_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;
  logic          wrap;

  assign state_cur = decode_state(state_q);

  always_comb begin
    state_d = state_cur;
    pcnt_d  = pcnt_q;
    clear_d = 1'b0;
    wrap    = 1'b0;

    case (state_cur)
      ST_RUNNING: begin
        if (pcnt_q == PCNT_MAX) begin
          pcnt_d = '0;
          wrap   = 1'b1;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_PAUSED: pcnt_d = pcnt_q;
      default:   pcnt_d = '0;
    endcase

    // Clear outranks run when both debounced presses land on the same edge.
    if (clear_press) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
    end else if (run_press) begin
      case (state_cur)
        ST_RUNNING: state_d = ST_PAUSED;
        default:    state_d = ST_RUNNING;
      endcase
    end

    if (state_d == ST_IDLE) pcnt_d = '0;

    // A wrap coinciding with a pause still ticks; one coinciding with clear does not.
    enable_d  = wrap & ~clear_press;
    running_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      enable_q  <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      enable_q  <= enable_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign enable  = enable_q;
  assign clear   = clear_q;
  assign running = running_q;

  // Observation point for bound checkers; not consumed by the datapath.
  ctrl_dbg_t unused_dbg;
  assign unused_dbg = '{state: state_cur, run_level: run_level, clear_level: clear_level};

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl with PRESCALE=4, DB_CYCLES=3: table vectors, hand sequences
// and randomized button traffic checked every cycle against a behavioural model.
module tb_count_ctrl;

  localparam int P  = 4;
  localparam int DB = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_run = 1'b0;
  logic btn_clear = 1'b0;
  logic enable, clear, running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen_en = 0;
  int seen_clr = 0;

  count_ctrl #(.PRESCALE(P), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .enable    (enable),
    .clear     (clear),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Reference model: raw -> 2-sample delay -> level accepted after DB mismatched samples,
  // then a mode plus a running-edge phase counted modulo P.
  int m_s1[2], m_s2[2], m_db[2], m_run[2];
  int m_mode = M_IDLE;
  int m_phase = 0;
  int m_en = 0, m_clr = 0, m_running = 0;

  task automatic model_step(input logic r, input logic c, input logic rst);
    int  raw[2];
    bit  ev[2];
    bit  tick;
    raw[0] = int'(r);
    raw[1] = int'(c);
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_run[b] = 0;
      end
      m_mode = M_IDLE; m_phase = 0; m_en = 0; m_clr = 0; m_running = 0;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      ev[b] = 1'b0;
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_db[b]  = m_s2[b];
          m_run[b] = 0;
          ev[b]    = (m_db[b] == 1);
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    tick = 1'b0;
    if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == P) begin
        m_phase = 0;
        tick = 1'b1;
      end
    end
    if (ev[1]) begin
      m_mode = M_IDLE; m_phase = 0; m_clr = 1; m_en = 0;
    end else begin
      m_clr = 0;
      m_en  = int'(tick);
      if (ev[0]) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    m_running = (m_mode == M_RUN) ? 1 : 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic cycle(input logic r, input logic c, input logic rst);
    btn_run = r;
    btn_clear = c;
    reset = rst;
    @(posedge clk);
    model_step(r, c, rst);
    @(negedge clk);
    cyc++;
    check("model_enable", int'(enable), m_en);
    check("model_clear", int'(clear), m_clr);
    check("model_running", int'(running), m_running);
    seen_en  += int'(enable);
    seen_clr += int'(clear);
  endtask

  typedef struct {
    logic run;
    logic clr;
    int   hold;
    logic exp_running;
    int   exp_en;
    int   exp_clr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int   trans;
    logic prev;
    logic r, c, rst;
    int   len;

    vecs[0]  = '{1'b1, 1'b0, 6,  1'b1, 0, 0};  // press run from IDLE
    vecs[1]  = '{1'b0, 1'b0, 10, 1'b1, 2, 0};  // steady ticks
    vecs[2]  = '{1'b1, 1'b0, 5,  1'b0, 2, 0};  // pause lands on wrap edge
    vecs[3]  = '{1'b0, 1'b0, 10, 1'b0, 0, 0};  // paused: no ticks
    vecs[4]  = '{1'b1, 1'b0, 5,  1'b1, 0, 0};  // resume
    vecs[5]  = '{1'b0, 1'b0, 3,  1'b1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 5,  1'b0, 1, 1};  // clear on wrap edge suppresses tick
    vecs[7]  = '{1'b0, 1'b0, 6,  1'b0, 0, 0};
    vecs[8]  = '{1'b0, 1'b1, 5,  1'b0, 0, 1};  // clear while IDLE still pulses
    vecs[9]  = '{1'b0, 1'b0, 6,  1'b0, 0, 0};
    vecs[10] = '{1'b1, 1'b1, 5,  1'b0, 0, 1};  // simultaneous: clear wins
    vecs[11] = '{1'b0, 1'b0, 6,  1'b0, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 5,  1'b1, 0, 0};
    vecs[13] = '{1'b0, 1'b0, 4,  1'b1, 1, 0};  // first tick after P running edges

    // Reset held with both buttons high.
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    check("rst_enable", int'(enable), 0);
    check("rst_clear", int'(clear), 0);
    check("rst_running", int'(running), 0);
    seen_clr = 0;
    cycle(1'b1, 1'b1, 1'b0);
    check("post_rst_running", int'(running), 0);
    check("post_rst_clear", int'(clear), 0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0);
    check("post_rst_clear_pulses", seen_clr, 1);
    check("post_rst_running_end", int'(running), 0);

    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      seen_en = 0;
      seen_clr = 0;
      repeat (vecs[i].hold) cycle(vecs[i].run, vecs[i].clr, 1'b0);
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_running));
      check($sformatf("vec%0d_enables", i), seen_en, vecs[i].exp_en);
      check($sformatf("vec%0d_clears", i), seen_clr, vecs[i].exp_clr);
    end

    // Bounce rejection from IDLE.
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    seen_en = 0;
    trans = 0;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (10) begin
      cycle(1'b0, 1'b0, 1'b0);
      trans += int'(running);
    end
    check("bounce_running_cycles", trans, 0);
    check("bounce_enables", seen_en, 0);

    // Held run button: one transition only, then release and re-press pauses.
    trans = 0;
    prev = running;
    repeat (50) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (running != prev) trans++;
      prev = running;
    end
    check("held_transitions", trans, 1);
    check("held_running", int'(running), 1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    check("repress_paused", int'(running), 0);

    // Resume, then reset mid-count: outputs drop with no clear pulse.
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    check("resume_running", int'(running), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("midrst_running", int'(running), 0);
    check("midrst_enable", int'(enable), 0);
    seen_clr = 0;
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    check("midrst_no_clear", seen_clr, 0);
    check("midrst_idle", int'(running), 0);

    // Randomized button traffic with occasional resets.
    repeat (600) begin
      r   = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 79) == 0);
      len = $urandom_range(1, 8);
      repeat (len) cycle(r, c, rst);
      if (rst) cycle(r, c, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
